// File: rtl/call_button_conditioner.sv
// Call-button front end: per-button 2-flop sync, debounce and rising-edge pulse.
// Optional `define CALL_LOCKOUT_EN adds a lockout input that blanks every output pulse.
module call_button_conditioner #(
    parameter int N_FLOORS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_BITS        = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef CALL_LOCKOUT_EN
    input  logic                lockout,
`endif
    input  logic [N_FLOORS-1:0] raw_up,
    input  logic [N_FLOORS-1:0] raw_down,
    input  logic [N_FLOORS-1:0] raw_floor,
    output logic [N_FLOORS-1:0] ext_up,
    output logic [N_FLOORS-1:0] ext_down,
    output logic [N_FLOORS-1:0] ext_floor
);

    localparam int                NCH      = 3 * N_FLOORS;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    // Channel order in the flattened vectors: [up | down | floor] from bit 0 upward.
    logic [NCH-1:0]      raw_all;
    logic [NCH-1:0]      sync1;
    logic [NCH-1:0]      sync2;
    logic [NCH-1:0]      stable;
    logic [NCH-1:0]      accept;
    logic [NCH-1:0]      rise;
    logic [NCH-1:0]      ch_mask;
    logic [NCH-1:0]      pulse_q;
    logic                out_en;
    logic [CNT_BITS-1:0] cnt [NCH];

    assign raw_all = {raw_floor, raw_down, raw_up};

`ifdef CALL_LOCKOUT_EN
    assign out_en = ~lockout;
`else
    assign out_en = 1'b1;
`endif

    // Up at the top floor and down at the ground floor can never be served.
    always_comb begin
        ch_mask               = '1;
        ch_mask[N_FLOORS-1]   = 1'b0;
        ch_mask[N_FLOORS]     = 1'b0;
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < NCH; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
        rise = accept & sync2;
    end

    // NOTE: sequential state uses non-blocking assignments so sync1->sync2 stays a true two-stage pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            stable  <= '0;
            pulse_q <= '0;
        end else begin
            sync1   <= raw_all;
            sync2   <= sync1;
            stable  <= stable ^ accept;
            pulse_q <= rise & ch_mask & {NCH{out_en}};
        end
    end

    // NOTE: the counter array is small flop storage, not RAM, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == stable[i] || accept[i]) cnt[i] <= '0;
                else                                     cnt[i] <= cnt[i] + CNT_BITS'(1);
            end
        end
    end

    assign ext_up    = pulse_q[N_FLOORS-1:0];
    assign ext_down  = pulse_q[2*N_FLOORS-1:N_FLOORS];
    assign ext_floor = pulse_q[3*N_FLOORS-1:2*N_FLOORS];

endmodule

// File: tb/tb_call_button_conditioner.sv
// Directed bench for call_button_conditioner (N_FLOORS=4, DEBOUNCE_CYCLES=4).
// Define CALL_LOCKOUT_EN for both files to exercise the lockout sequence.
module tb_call_button_conditioner;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         lockout;
    logic [N-1:0] raw_up, raw_down, raw_floor;
    logic [N-1:0] ext_up, ext_down, ext_floor;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string    name;
        int       n;
        logic [3:0] up, down, floor;
        logic [3:0] eu, ed, ef;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    call_button_conditioner #(
        .N_FLOORS       (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef CALL_LOCKOUT_EN
        .lockout  (lockout),
`endif
        .raw_up   (raw_up),
        .raw_down (raw_down),
        .raw_floor(raw_floor),
        .ext_up   (ext_up),
        .ext_down (ext_down),
        .ext_floor(ext_floor)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got up/down/floor=%h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] u, input logic [3:0] d, input logic [3:0] f);
        raw_up    = u;
        raw_down  = d;
        raw_floor = f;
    endtask

    task automatic run_const(input string name, input int n, input logic [11:0] exp);
        for (int c = 0; c < n; c++) begin
            step();
            check($sformatf("%s.%0d", name, c), {ext_up, ext_down, ext_floor}, exp);
        end
    endtask

    initial begin
        lockout = 1'b0;
        rst_n   = 1'b0;
        set_in('1, '1, '1);

        // Reset state: outputs held low even with every button pressed.
        #1;
        check("reset_async", {ext_up, ext_down, ext_floor}, 12'h000);
        run_const("reset_hold", 3, 12'h000);
        set_in('0, '0, '0);
        run_const("reset_drain", 2, 12'h000);
        rst_n = 1'b1;

        // Pulse lands on the 6th observed cycle after inputs change (1 + 1 + D edges).
        vq.push_back('{"idle",      2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
        vq.push_back('{"fl2_wait",  5, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0});
        vq.push_back('{"fl2_pulse", 1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h4});
        vq.push_back('{"fl2_held", 20, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0});
        vq.push_back('{"fl2_rel",   8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
        vq.push_back('{"sim_wait",  5, 4'h1, 4'h8, 4'h2, 4'h0, 4'h0, 4'h0});
        vq.push_back('{"sim_pulse", 1, 4'h1, 4'h8, 4'h2, 4'h1, 4'h8, 4'h2});
        vq.push_back('{"sim_held",  6, 4'h1, 4'h8, 4'h2, 4'h0, 4'h0, 4'h0});
        vq.push_back('{"sim_rel",   8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
        // Bounce: 3 high cycles (one short of D) then a 1-cycle dip restarts the count.
        vq.push_back('{"bnc_short", 3, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
        vq.push_back('{"bnc_dip",   1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
        vq.push_back('{"bnc_wait",  5, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
        vq.push_back('{"bnc_pulse", 1, 4'h2, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0});
        vq.push_back('{"bnc_held", 10, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
        vq.push_back('{"bnc_rel",   8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});

        foreach (vq[i]) begin
            set_in(vq[i].up, vq[i].down, vq[i].floor);
            run_const(vq[i].name, vq[i].n, {vq[i].eu, vq[i].ed, vq[i].ef});
        end

        // Masked channels: up at top floor and down at ground floor never pulse.
        set_in(4'h8, 4'h1, 4'h0);
        run_const("masked", 100, 12'h000);
        set_in('0, '0, '0);
        run_const("masked_rel", 8, 12'h000);

        // Reset mid-count: floor[0] held, reset asserted once its counter reaches 2.
        set_in(4'h0, 4'h0, 4'h1);
        run_const("rst_pre", 4, 12'h000);
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", {ext_up, ext_down, ext_floor}, 12'h000);
        run_const("rst_mid_hold", 5, 12'h000);
        rst_n = 1'b1;
        run_const("rst_post_wait", 5, 12'h000);
        run_const("rst_post_pulse", 1, 12'h001);
        run_const("rst_post_held", 10, 12'h000);
        set_in('0, '0, '0);
        run_const("rst_post_rel", 8, 12'h000);

`ifdef CALL_LOCKOUT_EN
        // Lockout covers the acceptance edge of floor[3]: the press is lost, not deferred.
        set_in(4'h0, 4'h0, 4'h8);
        run_const("lk_pre", 3, 12'h000);
        lockout = 1'b1;
        run_const("lk_on", 5, 12'h000);
        lockout = 1'b0;
        run_const("lk_held", 15, 12'h000);
        set_in('0, '0, '0);
        run_const("lk_rel", 8, 12'h000);
        set_in(4'h0, 4'h0, 4'h8);
        run_const("lk_rep_wait", 5, 12'h000);
        run_const("lk_rep_pulse", 1, 12'h008);
        run_const("lk_rep_held", 5, 12'h000);
        set_in('0, '0, '0);
        run_const("lk_rep_rel", 8, 12'h000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/call_button_conditioner.md
Name: call_button_conditioner

Overview:
- Upstream front-end for the elevator top level. It takes raw, asynchronous, bouncy hall and cab button levels.
- Per button it synchronises, debounces and edge-detects, producing clean single-cycle set pulses.
- Outputs drive ext_up / ext_down / ext_floor of the elevator top level, whose request flip-flop boards latch them.
- Also suppresses physically meaningless requests: up at the top floor, down at the ground floor.

Parameters:
- N_FLOORS, 4, number of floors; width of each button vector.
- DEBOUNCE_CYCLES, 16, consecutive synchronised cycles a new level must persist before it is accepted; legal range 1..65535.
- CNT_BITS, $clog2(DEBOUNCE_CYCLES+1), width of each per-channel debounce counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- raw_up  input  N_FLOORS  raw hall-up buttons, level, asynchronous, active-high.
- raw_down  input  N_FLOORS  raw hall-down buttons, level, asynchronous, active-high.
- raw_floor  input  N_FLOORS  raw cab floor-select buttons, level, asynchronous, active-high.
- ext_up  output  N_FLOORS  one-cycle press pulses, registered.
- ext_down  output  N_FLOORS  one-cycle press pulses, registered.
- ext_floor  output  N_FLOORS  one-cycle press pulses, registered.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous assert, active-low. While rst_n=0, every flop (sync stages, stable levels, counters, outputs) is 0.
- Channel structure: 3*N_FLOORS independent, identical channels (up, down, floor). There is no cross-channel interaction.
- Synchroniser: two flops per channel, sync1 <= raw, then sync2 <= sync1.
- Per channel state: stable (accepted level) and cnt (CNT_BITS wide).
- Debounce, evaluated each edge:
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch back to the stable level restarts the count from 0.
- Pulse generation:
  - The output bit is registered. It is 1 in exactly the cycle following the edge on which stable changes 0->1; otherwise it is 0.
  - A release (stable 1->0) produces no pulse.
  - A held button yields exactly one pulse.
- Latency: if raw is first sampled high at edge k and stays high, the pulse is high in the cycle after edge k+1+DEBOUNCE_CYCLES. Example: D=16 gives 17 edges from the first sampling edge.
- Minimum press: a raw high shorter than DEBOUNCE_CYCLES synchronised cycles produces no pulse.
- Re-press: requires stable to have returned to 0, i.e. a release lasting DEBOUNCE_CYCLES cycles.
- Masking:
  - ext_up[N_FLOORS-1] and ext_down[0] are constant 0 regardless of input.
  - Their channel logic may be optimised away.
  - ext_floor has no masking.
- Simultaneous presses: all channels pulse independently. Several pulses may occur in the same cycle.
- Reset mid-operation:
  - Counts and stable levels clear immediately.
  - A button still held after reset release is treated as a new press and pulses after the full latency.
- DEBOUNCE_CYCLES=1: a level is accepted on its first sync2 mismatch edge, so latency is 2 edges + 1.

Optional Feature:
- Macro: CALL_LOCKOUT_EN.
- When defined:
  - Adds input port lockout, 1 bit, after rst_n.
  - While lockout=1, all ext_* outputs are forced 0. Synchroniser and debounce state keep updating.
  - A press whose 0->1 acceptance falls inside lockout is lost; it is not deferred.
  - lockout is a synchronous-domain signal.
- When undefined: no lockout port; behaviour as above.

Test Plan:
- N_FLOORS=4, D=4: raw_floor[2] rises and is held -> ext_floor = 4'b0100 for exactly one cycle, 1+D edges after the first sampling edge; no further pulses while held.
- D=4: raw_up[1] high for 3 cycles, low for 1, then high and held -> one pulse only, timed from the final rise. Bounce restarts the count.
- raw_up[3] and raw_down[0] held 100 cycles -> ext_up and ext_down stay 0 throughout.
- raw_up[0], raw_down[3] and raw_floor[1] rise on the same cycle -> all three pulses coincide in one cycle; all other bits stay 0.
- Hold raw_floor[0]; assert rst_n=0 at cnt=2, release after 5 cycles -> outputs 0 during reset; one pulse 1+D edges after the first post-reset sampling edge.
- CALL_LOCKOUT_EN defined: lockout=1 spans the acceptance of raw_floor[3] -> no pulse. After release the button is held with no further pulse; release and re-press -> one pulse.
